// File: rtl/ttl_pkg.sv
// ttl_pkg: constants shared by the TTL-family models.
//   LS165_WIDTH      default number of shift stages (A..H)
//   LS165_SR_RST     per-bit reset value of the LS165 shift register
//   LS165_*_SYNC_RST reset values of the optional input synchronizer flops
//                    (idle-high clocks, shift mode, serial low)
package ttl_pkg;

  localparam int unsigned LS165_WIDTH = 8;
  localparam logic        LS165_SR_RST = 1'b0;

  localparam logic LS165_TTL_CLK_SYNC_RST = 1'b1;
  localparam logic LS165_CLK_INH_SYNC_RST = 1'b1;
  localparam logic LS165_SH_LD_N_SYNC_RST = 1'b1;
  localparam logic LS165_SER_SYNC_RST     = 1'b0;

endpackage

// File: rtl/ls165_if.sv
// ls165_if: pin-level bundle of the 74LS165 model.
//   ttl_clk  CLK pin (pin 2), treated as data
//   clk_inh  CLK INH pin (pin 15), active-high
//   sh_ld_n  SH/LD pin (pin 1): low = parallel load, high = shift
//   ser      serial input (pin 10), enters stage A
//   d        parallel inputs, d[0] = A ... d[WIDTH-1] = H
//   q7/q7_n  QH (pin 9) and /QH (pin 7)
// master drives the chip pins, slave is the chip itself.
interface ls165_if
  import ttl_pkg::*;
#(
  parameter int unsigned WIDTH = LS165_WIDTH
);

  logic             ttl_clk;
  logic             clk_inh;
  logic             sh_ld_n;
  logic             ser;
  logic [WIDTH-1:0] d;
  logic             q7;
  logic             q7_n;

  modport master (
    output ttl_clk, clk_inh, sh_ld_n, ser, d,
    input  q7, q7_n
  );

  modport slave (
    input  ttl_clk, clk_inh, sh_ld_n, ser, d,
    output q7, q7_n
  );

endinterface

// File: rtl/ttl_edge_det.sv
// ttl_edge_det: rising-edge detector for a signal sampled on clk.
//   clk   system clock
//   rst_n synchronous active-low reset; history resets to 1 so a signal
//         that is already high at reset release gives no edge
//   sig   sampled level
//   rise  one-cycle pulse when sig is 1 and was 0 on the previous cycle
module ttl_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic hist;

  always_ff @(posedge clk) begin
    if (!rst_n) hist <= 1'b1;
    else        hist <= sig;
  end

  assign rise = sig & ~hist;

endmodule

// File: rtl/ls165.sv
// ls165: clk-synchronous model of the 74LS165 8-bit parallel-in/serial-out
// shift register.
//   clk    system clock, every register updates on its rising edge
//   rst_n  synchronous active-low reset (sr cleared, no pending edge)
//   bus    ls165_if.slave: ttl_clk, clk_inh, sh_ld_n, ser, d in; q7, q7_n out
// The chip's shift clock is the gate ttl_clk | clk_inh; a shift happens on
// a sampled rising edge of that gate (including the clk_inh-rises-while-
// ttl_clk-low hazard of the real part). Load is level-sensitive and beats
// shift; the gate history still tracks during load.
// Optional feature: define LS165_INPUT_SYNC_EN to pass ttl_clk, clk_inh,
// sh_ld_n and ser through 2-flop synchronizers (d stays direct), adding
// 2 cycles of latency.
module ls165
  import ttl_pkg::*;
#(
  parameter int unsigned WIDTH = LS165_WIDTH
) (
  input logic    clk,
  input logic    rst_n,
  ls165_if.slave bus
);

  logic ttl_clk_i;
  logic clk_inh_i;
  logic sh_ld_n_i;
  logic ser_i;

`ifdef LS165_INPUT_SYNC_EN
  logic [1:0] ttl_clk_s;
  logic [1:0] clk_inh_s;
  logic [1:0] sh_ld_n_s;
  logic [1:0] ser_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ttl_clk_s <= {2{LS165_TTL_CLK_SYNC_RST}};
      clk_inh_s <= {2{LS165_CLK_INH_SYNC_RST}};
      sh_ld_n_s <= {2{LS165_SH_LD_N_SYNC_RST}};
      ser_s     <= {2{LS165_SER_SYNC_RST}};
    end else begin
      ttl_clk_s <= {ttl_clk_s[0], bus.ttl_clk};
      clk_inh_s <= {clk_inh_s[0], bus.clk_inh};
      sh_ld_n_s <= {sh_ld_n_s[0], bus.sh_ld_n};
      ser_s     <= {ser_s[0], bus.ser};
    end
  end

  assign ttl_clk_i = ttl_clk_s[1];
  assign clk_inh_i = clk_inh_s[1];
  assign sh_ld_n_i = sh_ld_n_s[1];
  assign ser_i     = ser_s[1];
`else
  assign ttl_clk_i = bus.ttl_clk;
  assign clk_inh_i = bus.clk_inh;
  assign sh_ld_n_i = bus.sh_ld_n;
  assign ser_i     = bus.ser;
`endif

  logic             gclk;
  logic             gclk_rise;
  logic [WIDTH-1:0] sr;

  // Same OR gate as the chip, so the inhibit-pin hazard is reproduced.
  assign gclk = ttl_clk_i | clk_inh_i;

  // The detector's history runs every cycle, independent of load, so a
  // load released with gclk already high does not produce a shift.
  ttl_edge_det u_gclk_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (gclk),
    .rise  (gclk_rise)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)          sr <= {WIDTH{LS165_SR_RST}};
    else if (!sh_ld_n_i) sr <= bus.d;
    else if (gclk_rise)  sr <= {sr[WIDTH-2:0], ser_i};
  end

  assign bus.q7   = sr[WIDTH-1];
  assign bus.q7_n = ~sr[WIDTH-1];

endmodule

// File: doc/ls165.md
LS165 -- requirements
Module: ls165

Interface
- REQ-001 Parameter: WIDTH, 8, number of shift stages (A..H for WIDTH=8; d[WIDTH-1] is input H).
- REQ-002 Port: clk  input  1  system clock. Every register in the block updates on its rising edge.
- REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
- REQ-004 Port: ttl_clk  input  1  chip CLK pin (pin 2), sampled as data on clk.
- REQ-005 Port: clk_inh  input  1  chip CLK INH pin (pin 15), active-high.
- REQ-006 Port: sh_ld_n  input  1  chip SH/LD pin (pin 1): low = parallel load, high = shift.
- REQ-007 Port: ser  input  1  serial input (pin 10), shifted into stage A.
- REQ-008 Port: d  input  WIDTH  parallel inputs A..H (pins 11-14, 3-6); d[0]=A.
- REQ-009 Port: q7  output  1  last stage QH (pin 9).
- REQ-010 Port: q7_n  output  1  complement output /QH (pin 7).
- REQ-011 Decided: one clock (clk); reset rst_n is synchronous and active-low.

Function
- REQ-012 The internal shift clock is gclk = ttl_clk OR clk_inh, modelling the chip's gate exactly.
- REQ-013 A shift event is a sampled gclk rising edge: previous-cycle gclk = 0 and current gclk = 1.
- REQ-014 Load is level-sensitive. While sh_ld_n is sampled low, sr <= d on every clk edge, so d changes propagate one cycle later.
- REQ-015 Load has priority. A gclk rising edge while sh_ld_n is low does not shift.
- REQ-016 On a shift event with sh_ld_n high: sr <= {sr[WIDTH-2:0], ser}. H is the first bit out and A moves toward H.
- REQ-017 The gclk history register updates every cycle, whatever the state of load, so that when load is released with gclk already high, no shift occurs.
- REQ-018 Consequence of REQ-012: clk_inh rising while ttl_clk is low is a shift event (datasheet hazard), reproduced deliberately. clk_inh rising while ttl_clk is high is not a shift event.
- REQ-019 q7 = sr[WIDTH-1] and q7_n = ~sr[WIDTH-1]. Both are combinational from the register and never disagree.
- REQ-020 Latency without REQ-028: load and shift results are visible at q7 one clk cycle after the causing input is applied.
- REQ-021 At most one shift occurs per gclk rising edge, regardless of how long gclk stays high.

Reset
- REQ-022 With rst_n sampled low: sr <= 0 and gclk history <= 1. This gives q7=0 and q7_n=1 on the following cycle.
- REQ-023 Reset overrides load and shift. If gclk is still high at release, the first cycle after release produces no shift.
- REQ-024 If reset is asserted in mid-shift-sequence, the partially shifted data is discarded and no pending edge survives reset.

Configuration
- REQ-025 Macro LS165_INPUT_SYNC_EN. When defined, ttl_clk, clk_inh, sh_ld_n and ser each pass through a 2-flop synchronizer before use.
- REQ-026 With the macro defined, synchronizer flops reset to ttl_clk=1, clk_inh=1, sh_ld_n=1 and ser=0, and d is not synchronized.
- REQ-027 Without the macro, inputs are used directly and REQ-020 latency applies.
- REQ-028 With the macro, load and shift latency becomes 3 clk cycles. All relative ordering rules are unchanged.

Structure
- REQ-029 Shared package ttl_pkg holds the LS165 default width constant and the sr reset value constant.
- REQ-030 Gated-edge detection is a sub-module ttl_edge_det. Its inputs are clk, rst_n and sig. Its output is rise, a 1-cycle pulse, and its history register resets to 1.
- REQ-031 ls165 instantiates exactly one ttl_edge_det, which operates on gclk.

Verification
- REQ-032 Reset: with rst_n low for 2 cycles and ttl_clk=1, then release, q7=0 and q7_n=1, and no shift occurs while ttl_clk stays high.
- REQ-033 Load/shift-out: load d=8'b1010_0110, then apply 8 ttl_clk pulses with ser=1 and clk_inh=0. q7 must read 1,0,1,0,0,1,1,0 and then stay 1, with q7_n always the inverse.
- REQ-034 Inhibit: with clk_inh=1 held, apply 5 ttl_clk pulses. q7 must be unchanged. Then drop clk_inh while ttl_clk is high: no shift.
- REQ-035 Hazard: with ttl_clk=0 and sh_ld_n=1, raise clk_inh 0->1. There must be exactly one shift.
- REQ-036 Priority and release: hold sh_ld_n low during a ttl_clk rising edge, with d=8'hFF. sr must equal FF and no shift occurs. Raise sh_ld_n while ttl_clk is high: no shift until the next rising edge.
- REQ-037 Build with LS165_INPUT_SYNC_EN and repeat REQ-033. The q7 sequence must be identical, with every change delayed by exactly 2 extra cycles.
